tcdm_bank_resp: RTL
===================

Name: tcdm_bank_resp

Overview:
- Responder end of the TCDM bank port: one SRAM bank plus its request/grant/response handshake.
- Connects to one bank-side port of the TCDM interconnect (req/gnt/add/wen/wdata/be in, rdata out).
- Returns read data exactly RespLat cycles after a granted read.
- Supports externally injected stalls to exercise interconnect backpressure, and keeps saturating access counters for bench and performance observation.

Parameters:
- AddrMemWidth, 12, word-address bits of the bank; depth = 2**AddrMemWidth words.
- DataWidth, 32, word width; multiple of 8.
- BeWidth, DataWidth/8, byte-enable width.
- RespLat, 1, cycles from granted read to valid rdata_o; must be >= 1 (fatal at elaboration otherwise).
- CntWidth, 32, width of each statistics counter.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  access request from interconnect.
- gnt_o  out  1  grant; combinational, gnt_o = req_i & ~stall_i.
- add_i  in  AddrMemWidth  word address within bank.
- wen_i  in  1  1: store, 0: load.
- wdata_i  in  DataWidth  write data.
- be_i  in  BeWidth  byte enables; bit b covers byte b.
- rdata_o  out  DataWidth  read response data.
- stall_i  in  1  1: refuse grant this cycle.
- rd_cnt_o  out  CntWidth  granted loads since reset.
- wr_cnt_o  out  CntWidth  granted stores since reset.
- stall_cnt_o  out  CntWidth  cycles with req_i=1 and stall_i=1.

Behaviour:
- Access is granted in cycle t iff req_i=1 and stall_i=0. No state changes for ungranted requests.
- Granted store: at the end of cycle t, for each b with be_i[b]=1, mem[add_i] byte b <= wdata_i byte b. Other bytes are unchanged. be_i=0 is a legal no-op write but still counts in wr_cnt_o.
- Granted load: mem[add_i] is sampled at the end of cycle t, passed through a RespLat-stage shift register, and presented on rdata_o during cycle t+RespLat.
- The response pipeline carries a valid bit per stage. rdata_o updates only when a valid entry leaves the last stage; otherwise it holds its last value.
- Back-to-back loads are fully pipelined: one load per cycle, one response per cycle.
- Store at t followed by a load of the same address at t+1 returns the new data (write-first ordering across cycles). A single port means no same-cycle read/write conflict.
- No buffering: the block never queues requests; a stall simply withholds gnt_o.
- Counters increment by 1 on their event and saturate at 2**CntWidth-1 (no wrap).
- Reset (rst_i=1 at a clock edge), including mid-operation:
  - pipeline valid bits cleared; in-flight read responses are discarded and never appear;
  - rdata_o <= 0;
  - all counters <= 0.
- Memory contents are not reset and are retained across reset.
- gnt_o is combinational and not masked by reset; the interconnect must hold req_i=0 during reset. Accesses presented while rst_i=1 are ignored: no write, no response, no count.
- Outputs after reset: rdata_o=0, rd_cnt_o=0, wr_cnt_o=0, stall_cnt_o=0; gnt_o follows req_i & ~stall_i.

Test Plan:
- Write/read, RespLat=1: store 0xDEADBEEF to addr 0x010 with be=0xF at cycle 0, load addr 0x010 at cycle 1 -> gnt_o=1 both cycles; rdata_o=0xDEADBEEF in cycle 2; wr_cnt_o=1, rd_cnt_o=1.
- Byte enables: mem[0x020]=0x11223344, then store 0xAABBCCDD with be=0b0101, then load -> rdata_o=0x11BB33DD.
- Latency and pipelining, RespLat=3: loads of addr 1,2,3 (preloaded with 0xA1,0xA2,0xA3) in cycles 10,11,12 -> rdata_o=0xA1/0xA2/0xA3 in cycles 13/14/15; rdata_o holds 0xA3 in cycle 16 with no further requests.
- Stall: req_i=1 with stall_i=1 for cycles 0-3, stall_i=0 at cycle 4 -> gnt_o=0 in cycles 0-3 and 1 in cycle 4; stall_cnt_o=4; exactly one access performed.
- Reset mid-flight, RespLat=2: load granted at cycle 5, rst_i=1 at cycle 6 -> no response appears; rdata_o=0 and counters=0 after cycle 6; a subsequent load of the same address returns the pre-reset stored value.
- Saturation, CntWidth=4: 20 granted loads -> rd_cnt_o stops at 15.

Source files
------------

// File: rtl/tcdm_bank_resp.sv
// ============================================================================
// Module   : tcdm_bank_resp
// Brief    : TCDM bank responder - single-port SRAM bank with req/gnt handshake,
//            fixed-latency read response, injected stalls and access counters.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tcdm_bank_resp #(
    parameter int unsigned ADDR_MEM_WIDTH = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned RESP_LAT       = 1,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [ADDR_MEM_WIDTH-1:0] add_i,
    input  logic                      wen_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [BE_WIDTH-1:0]       be_i,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    input  logic                      stall_i,
    output logic [CNT_WIDTH-1:0]      rd_cnt_o,
    output logic [CNT_WIDTH-1:0]      wr_cnt_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

    localparam int unsigned c_DEPTH = 2 ** ADDR_MEM_WIDTH;

    if (RESP_LAT < 1) begin : g_lat_check
        $fatal(1, "tcdm_bank_resp: RESP_LAT must be >= 1");
    end

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [CNT_WIDTH-1:0]  r_rd_cnt;
    logic [CNT_WIDTH-1:0]  r_wr_cnt;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    logic                  w_gnt;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_stalled;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_out_vld;
    logic [DATA_WIDTH-1:0] w_out_dat;

    // Grant is deliberately not masked by reset; accesses during reset are
    // suppressed on the state-update side instead.
    assign w_gnt     = req_i & ~stall_i;
    assign w_rd      = w_gnt & ~wen_i & ~rst_i;
    assign w_wr      = w_gnt &  wen_i & ~rst_i;
    assign w_stalled = req_i &  stall_i;
    assign w_rd_data = r_mem[add_i];

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int b = 0; b < int'(BE_WIDTH); b++) begin
                if (be_i[b]) begin
                    r_mem[add_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // rdata_o is itself the final latency stage, so only RESP_LAT-1 extra
    // stages sit between the memory read and the output register.
    if (RESP_LAT == 1) begin : g_direct
        assign w_out_vld = w_rd;
        assign w_out_dat = w_rd_data;
    end else begin : g_shift
        logic [RESP_LAT-2:0]   r_vld;
        logic [DATA_WIDTH-1:0] r_dat [RESP_LAT-1];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= w_rd;
                for (int i = 1; i < int'(RESP_LAT) - 1; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            r_dat[0] <= w_rd_data;
            for (int i = 1; i < int'(RESP_LAT) - 1; i++) begin
                r_dat[i] <= r_dat[i-1];
            end
        end

        assign w_out_vld = r_vld[RESP_LAT-2];
        assign w_out_dat = r_dat[RESP_LAT-2];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else if (w_out_vld) begin
            r_rdata <= w_out_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_rd && (r_rd_cnt != {CNT_WIDTH{1'b1}})) begin
                r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
            end
            if (w_wr && (r_wr_cnt != {CNT_WIDTH{1'b1}})) begin
                r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
            end
            if (w_stalled && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign gnt_o       = w_gnt;
    assign rdata_o     = r_rdata;
    assign rd_cnt_o    = r_rd_cnt;
    assign wr_cnt_o    = r_wr_cnt;
    assign stall_cnt_o = r_stall_cnt;

endmodule

`default_nettype wire
